// File: rtl/tpu_cmd_sequencer.sv
// Command sequencer for the TensorFlowE engine's byte-serial control pins.
// Define SEQ_READ_TIMEOUT_EN to bound the wait for eng_out_valid after each read strobe.
module tpu_cmd_sequencer #(
    parameter int PULSE_W  = 2,
    parameter int GAP_W    = 2,
    parameter int MUL_WAIT = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  eng_data,
    output logic        eng_write,
    output logic        eng_accu,
    output logic        eng_clear,
    output logic        eng_read,
    input  logic        eng_out_valid,
    input  logic [7:0]  eng_out_data
);

    localparam int S    = PULSE_W + GAP_W;
    localparam int M1   = (TIMEOUT > MUL_WAIT) ? TIMEOUT : MUL_WAIT;
    localparam int MAXC = (M1 > S) ? M1 : S;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MAC   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, SEND, MWAIT, ACCU, CLR, RD_STB, RD_WAIT, RSP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    op_q, op_d;
    logic [15:0]   a_q, a_d;
    logic [15:0]   b_q, b_d;
    logic [15:0]   rsp_data_q, rsp_data_d;
    logic [7:0]    eng_data_q, eng_data_d;
    logic          eng_write_q, eng_write_d;
    logic          eng_accu_q, eng_accu_d;
    logic          eng_clear_q, eng_clear_d;
    logic          eng_read_q, eng_read_d;
    logic          strobe_done;
    logic          strobe_hi;
`ifdef SEQ_READ_TIMEOUT_EN
    logic          rsp_err_q, rsp_err_d;
`endif

    // cnt walks 0..S-1 across one strobe window: high for the first PULSE_W, low for the rest.
    assign strobe_done = (cnt_q == CW'(S - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
`ifdef SEQ_READ_TIMEOUT_EN
        rsp_err_d  = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    a_d        = cmd_a;
                    b_d        = cmd_b;
                    cnt_d      = '0;
                    idx_d      = 2'd0;
                    rsp_data_d = '0;
`ifdef SEQ_READ_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
`endif
                    case (cmd_op)
                        OP_MUL, OP_MAC: state_d = SEND;
                        OP_CLEAR:       state_d = CLR;
                        OP_READ:        state_d = RD_STB;
                    endcase
                end
            end
            SEND: begin
                if (strobe_done) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) state_d = MWAIT;
                    else               idx_d   = idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MWAIT: begin
                if (cnt_q == CW'(MUL_WAIT - 1)) begin
                    cnt_d   = '0;
                    state_d = (op_q == OP_MUL) ? RSP : ACCU;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACCU, CLR: begin
                if (strobe_done) begin
                    cnt_d   = '0;
                    state_d = RSP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_STB: begin
                if (strobe_done) begin
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_WAIT: begin
                if (eng_out_valid) begin
                    if (idx_q[0]) begin
                        rsp_data_d[15:8] = eng_out_data;
                        state_d          = RSP;
                    end else begin
                        rsp_data_d[7:0] = eng_out_data;
                        idx_d           = 2'd1;
                        cnt_d           = '0;
                        state_d         = RD_STB;
                    end
                end
`ifdef SEQ_READ_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RSP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from next state so they come straight off flops.
    always_comb begin
        strobe_hi   = (cnt_d < CW'(PULSE_W));
        eng_write_d = (state_d == SEND)   && strobe_hi;
        eng_accu_d  = (state_d == ACCU)   && strobe_hi;
        eng_clear_d = (state_d == CLR)    && strobe_hi;
        eng_read_d  = (state_d == RD_STB) && strobe_hi;
        eng_data_d  = 8'h00;
        if (state_d == SEND) begin
            case (idx_d)
                2'd0: eng_data_d = a_d[7:0];
                2'd1: eng_data_d = a_d[15:8];
                2'd2: eng_data_d = b_d[7:0];
                2'd3: eng_data_d = b_d[15:8];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            op_q        <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            eng_data_q  <= '0;
            eng_write_q <= 1'b0;
            eng_accu_q  <= 1'b0;
            eng_clear_q <= 1'b0;
            eng_read_q  <= 1'b0;
`ifdef SEQ_READ_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_data_q  <= rsp_data_d;
            eng_data_q  <= eng_data_d;
            eng_write_q <= eng_write_d;
            eng_accu_q  <= eng_accu_d;
            eng_clear_q <= eng_clear_d;
            eng_read_q  <= eng_read_d;
`ifdef SEQ_READ_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_data  = rsp_data_q;
`ifdef SEQ_READ_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif
    assign eng_data  = eng_data_q;
    assign eng_write = eng_write_q;
    assign eng_accu  = eng_accu_q;
    assign eng_clear = eng_clear_q;
    assign eng_read  = eng_read_q;

endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// Directed scoreboard bench for tpu_cmd_sequencer with a small engine read model.
module tb_tpu_cmd_sequencer;

    localparam int PULSE_W  = 2;
    localparam int GAP_W    = 2;
    localparam int MUL_WAIT = 8;
    localparam int TIMEOUT  = 64;
    localparam int S        = PULSE_W + GAP_W;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MAC   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  eng_data;
    logic        eng_write;
    logic        eng_accu;
    logic        eng_clear;
    logic        eng_read;
    logic        eng_out_valid = 1'b0;
    logic [7:0]  eng_out_data  = 8'h00;

    always #5 clk = ~clk;

    tpu_cmd_sequencer #(
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W),
        .MUL_WAIT(MUL_WAIT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .eng_data     (eng_data),
        .eng_write    (eng_write),
        .eng_accu     (eng_accu),
        .eng_clear    (eng_clear),
        .eng_read     (eng_read),
        .eng_out_valid(eng_out_valid),
        .eng_out_data (eng_out_data)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] eng_bytes[$];
    bit         eng_en = 1'b1;

    // Engine model: each read strobe drops Ena_out, which rises three cycles later with the next byte.
    logic       prev_rd = 1'b0;
    int         eng_dly = 0;
    logic [7:0] eng_byte = 8'h00;
    always @(negedge clk) begin
        if (eng_read === 1'b1 && prev_rd !== 1'b1) begin
            eng_out_valid = 1'b0;
            if (eng_en && eng_bytes.size() > 0) begin
                eng_byte = eng_bytes.pop_front();
                eng_dly  = 3;
            end
        end else if (eng_dly > 0) begin
            eng_dly--;
            if (eng_dly == 0) begin
                eng_out_valid = 1'b1;
                eng_out_data  = eng_byte;
            end
        end
        prev_rd = eng_read;
    end

    // Strobe monitor: one-hot, pulse width, write spacing and data hold, strobe counts.
    bit         mon_en = 1'b0;
    logic [3:0] s_prev = 4'b0;
    int         hi_len = 0;
    int         lo_len = 0;
    bit         last_w = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    int         n_write = 0, n_accu = 0, n_clear = 0, n_read = 0;
    always @(negedge clk) begin
        logic [3:0] s;
        if (mon_en) begin
            s = {eng_write, eng_accu, eng_clear, eng_read};
            if (rsp_valid === 1'b1 || busy !== 1'b1) last_w = 1'b0;
            if (s != 4'b0) begin
                check("strobe_onehot", $countones(s), 1);
                if (s_prev == 4'b0) begin
                    if (eng_write) begin
                        n_write++;
                        if (last_w) check("write_gap", lo_len, GAP_W);
                        check("write_expected", exp_bytes.size() != 0, 1);
                        if (exp_bytes.size() != 0) begin
                            cur_byte = exp_bytes.pop_front();
                            check("write_byte", eng_data, cur_byte);
                        end
                    end
                    if (eng_accu)  n_accu++;
                    if (eng_clear) n_clear++;
                    if (eng_read)  n_read++;
                    last_w = eng_write;
                end else if (eng_write) begin
                    check("write_data_hold", eng_data, cur_byte);
                end
                hi_len++;
                lo_len = 0;
            end else begin
                if (hi_len != 0) check("pulse_width", hi_len, PULSE_W);
                hi_len = 0;
                lo_len++;
                if (last_w && busy === 1'b1 && lo_len <= GAP_W)
                    check("write_data_gap", eng_data, cur_byte);
            end
            s_prev = s;
        end
    end

    task automatic do_cmd(input string tag, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] edata, input logic eerr, input int elat,
                          input int hold, input int ew, input int ea, input int ec, input int er,
                          input bit keep, input logic [1:0] next_op);
        exp_t e;
        int   n;
        int   w0, a0, c0, r0;
        e.data = edata;
        e.err  = eerr;
        e.lat  = elat;
        sb.push_back(e);
        if (op == OP_MUL || op == OP_MAC) begin
            exp_bytes.push_back(a[7:0]);
            exp_bytes.push_back(a[15:8]);
            exp_bytes.push_back(b[7:0]);
            exp_bytes.push_back(b[15:8]);
        end
        w0 = n_write; a0 = n_accu; c0 = n_clear; r0 = n_read;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept_bound"}, n < 500, 1);
        @(negedge clk);
        if (keep) cmd_op = next_op;
        else      cmd_valid = 1'b0;
        check({tag, "_ready_low"}, cmd_ready, 0);
        check({tag, "_busy"}, busy, 1);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
            if (keep && rsp_valid !== 1'b1) check({tag, "_held_not_taken"}, cmd_ready, 0);
        end
        e = sb.pop_front();
        check({tag, "_latency"}, n, e.lat);
        if (hold > 0) begin
            rsp_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, rsp_valid, 1);
                check({tag, "_hold_data"}, rsp_data, e.data);
            end
            rsp_ready = 1'b1;
        end
        check({tag, "_data"}, rsp_data, e.data);
        check({tag, "_err"}, rsp_err, e.err);
        $display("txn %s op=%0d a=0x%04h b=0x%04h latency=%0d data=0x%04h err=%0b",
                 tag, op, a, b, n, rsp_data, rsp_err);
        @(negedge clk);
        check({tag, "_one_cycle_rsp"}, rsp_valid, 0);
        check({tag, "_ready_back"}, cmd_ready, 1);
        check({tag, "_n_write"}, n_write - w0, ew);
        check({tag, "_n_accu"}, n_accu - a0, ea);
        check({tag, "_n_clear"}, n_clear - c0, ec);
        check({tag, "_n_read"}, n_read - r0, er);
    endtask

    initial begin
        int w0;
        int k;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = 16'h0000;
        cmd_b     = 16'h0000;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_eng", {eng_data, eng_write, eng_accu, eng_clear, eng_read}, 0);
        $display("txn reset released");
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        do_cmd("mul", OP_MUL, 16'h1234, 16'hABCD, 16'h0000, 1'b0, 1 + 4*S + MUL_WAIT,
               0, 4, 0, 0, 0, 1'b0, 2'b00);
        do_cmd("mac", OP_MAC, 16'h0102, 16'h0304, 16'h0000, 1'b0, 1 + 5*S + MUL_WAIT,
               0, 4, 1, 0, 0, 1'b0, 2'b00);

        eng_bytes.push_back(8'h78);
        eng_bytes.push_back(8'h56);
        do_cmd("read", OP_READ, 16'h0000, 16'h0000, 16'h5678, 1'b0, 1 + 2*S + 2,
               5, 0, 0, 0, 2, 1'b0, 2'b00);

        do_cmd("mul_after_read", OP_MUL, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1 + 4*S + MUL_WAIT,
               0, 4, 0, 0, 0, 1'b0, 2'b00);

`ifdef SEQ_READ_TIMEOUT_EN
        eng_en = 1'b0;
        do_cmd("read_timeout", OP_READ, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1 + S + TIMEOUT,
               0, 0, 0, 0, 1, 1'b0, 2'b00);
        eng_en = 1'b1;
`endif

        // Reset lands in the low window of the third operand byte.
        w0 = n_write;
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        exp_bytes.push_back(8'h33);
        cmd_valid = 1'b1;
        cmd_op    = OP_MUL;
        cmd_a     = 16'h2211;
        cmd_b     = 16'h4433;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_eng_zero", {eng_data, eng_write, eng_accu, eng_clear, eng_read}, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_writes", n_write - w0, 3);
        k = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) k++;
        end
        check("abort_no_rsp", k, 0);
        $display("txn mul aborted by reset after %0d writes", n_write - w0);
        do_cmd("clear_after_rst", OP_CLEAR, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1 + S,
               0, 0, 0, 1, 0, 1'b0, 2'b00);

        do_cmd("clear_held", OP_CLEAR, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1 + S,
               0, 0, 0, 1, 0, 1'b1, OP_MUL);
        do_cmd("mul_queued", OP_MUL, 16'h00FF, 16'hFF00, 16'h0000, 1'b0, 1 + 4*S + MUL_WAIT,
               0, 4, 0, 0, 0, 1'b0, 2'b00);

        check("final_bytes_drained", exp_bytes.size(), 0);
        check("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
